// File: rtl/haar_window_feature_if.sv
// Bus between the integral-window buffer, the Haar feature stage and the detection stage.
// Widths derive from the same geometry parameters as haar_window_feature.
interface haar_window_feature_if #(
  parameter int ImageWidth  = 640,
  parameter int ImageHeight = 480,
  parameter int WindowSize  = 21
);
  localparam int IW = $clog2(WindowSize*WindowSize+1);
  localparam int CW = $clog2(WindowSize);
  localparam int XW = $clog2(ImageWidth);
  localparam int YW = $clog2(ImageHeight);
  localparam int DW = IW + 1;

  logic                            InValid;
  logic                            BufferReady;
  logic [IW*WindowSize*WindowSize-1:0] IntegralPacked;
  logic [CW-1:0]                   RectAX0, RectAY0, RectAX1, RectAY1;
  logic [CW-1:0]                   RectBX0, RectBY0, RectBX1, RectBY1;
  logic [DW-1:0]                   Threshold;
  logic                            OutValid;
  logic [DW-1:0]                   OutDiff;
  logic                            OutMatch;
  logic [XW-1:0]                   OutX;
  logic [YW-1:0]                   OutY;
  logic                            FrameDone;

  modport master (
    output InValid, BufferReady, IntegralPacked,
    output RectAX0, RectAY0, RectAX1, RectAY1,
    output RectBX0, RectBY0, RectBX1, RectBY1, Threshold,
    input  OutValid, OutDiff, OutMatch, OutX, OutY, FrameDone
  );

  modport slave (
    input  InValid, BufferReady, IntegralPacked,
    input  RectAX0, RectAY0, RectAX1, RectAY1,
    input  RectBX0, RectBY0, RectBX1, RectBY1, Threshold,
    output OutValid, OutDiff, OutMatch, OutX, OutY, FrameDone
  );
endinterface

// File: rtl/haar_window_feature.sv
// Two-rectangle Haar feature over an integral window: 3-stage pipeline, one result per strobe.
// Define HAAR_FEATURE_ABS_EN to output |A-B| and compare the magnitude against Threshold.
module haar_window_feature #(
  parameter int ImageWidth  = 640,
  parameter int ImageHeight = 480,
  parameter int WindowSize  = 21
) (
  input logic                  Clock,
  input logic                  Reset,
  haar_window_feature_if.slave Bus
);
  localparam int N  = WindowSize;
  localparam int IW = $clog2(N*N+1);
  localparam int CW = $clog2(N);
  localparam int XW = $clog2(ImageWidth);
  localparam int YW = $clog2(ImageHeight);
  localparam int DW = IW + 1;
  localparam int PW = IW*N*N;

  // Corner coordinates of -1 fall outside the window and read as zero.
  function automatic logic [IW-1:0] readEntry(input logic [PW-1:0] win, input int x, input int y);
    logic [IW-1:0] e;
    e = '0;
    if (x >= 0 && y >= 0 && x < N && y < N) e = win[IW*(N*y+x) +: IW];
    return e;
  endfunction

  // Packed as {D, B, C, A}.
  function automatic logic [4*IW-1:0] rectCorners(input logic [PW-1:0] win,
      input logic [CW-1:0] x0, input logic [CW-1:0] y0,
      input logic [CW-1:0] x1, input logic [CW-1:0] y1);
    int xa, ya, xb, yb;
    xa = int'(x0) - 1;
    ya = int'(y0) - 1;
    xb = int'(x1);
    yb = int'(y1);
    return {readEntry(win, xb, yb), readEntry(win, xa, yb),
            readEntry(win, xb, ya), readEntry(win, xa, ya)};
  endfunction

  // The true sum always lies in 0..n*n, so modulo-2^IW arithmetic gives it exactly.
  function automatic logic [IW-1:0] rectSum(input logic [4*IW-1:0] c,
      input logic [CW-1:0] x0, input logic [CW-1:0] y0,
      input logic [CW-1:0] x1, input logic [CW-1:0] y1);
    logic [IW-1:0] s;
    s = c[4*IW-1 -: IW] - c[3*IW-1 -: IW] - c[2*IW-1 -: IW] + c[IW-1:0];
    if (x0 > x1 || y0 > y1) s = '0;
    return s;
  endfunction

  logic [XW-1:0]        col_q;
  logic [YW-1:0]        row_q;
  logic                 frameDone_q;
  logic                 v1_q, v2_q;
  logic [4*IW-1:0]      cornA_q, cornB_q, cornA_d, cornB_d;
  logic [XW-1:0]        x1_q, x2_q, x1_d;
  logic [YW-1:0]        y1_q, y2_q, y1_d;
  logic [IW-1:0]        sumA_q, sumB_q, sumA_d, sumB_d;
  logic                 qual;
  logic signed [DW-1:0] diffSigned;
  logic [DW-1:0]        diff_d;
  logic                 match_d;
  logic                 outValid_q, outMatch_q;
  logic [DW-1:0]        outDiff_q;
  logic [XW-1:0]        outX_q;
  logic [YW-1:0]        outY_q;

  always_comb begin
    qual    = Bus.InValid & Bus.BufferReady & (col_q >= XW'(N-1)) & (row_q >= YW'(N-1));
    cornA_d = rectCorners(Bus.IntegralPacked, Bus.RectAX0, Bus.RectAY0, Bus.RectAX1, Bus.RectAY1);
    cornB_d = rectCorners(Bus.IntegralPacked, Bus.RectBX0, Bus.RectBY0, Bus.RectBX1, Bus.RectBY1);
    x1_d    = col_q - XW'(N-1);
    y1_d    = row_q - YW'(N-1);
    sumA_d  = rectSum(cornA_q, Bus.RectAX0, Bus.RectAY0, Bus.RectAX1, Bus.RectAY1);
    sumB_d  = rectSum(cornB_q, Bus.RectBX0, Bus.RectBY0, Bus.RectBX1, Bus.RectBY1);
    diffSigned = $signed({1'b0, sumA_q}) - $signed({1'b0, sumB_q});
`ifdef HAAR_FEATURE_ABS_EN
    diff_d = diffSigned[DW-1] ? DW'(-diffSigned) : DW'(diffSigned);
`else
    diff_d = DW'(diffSigned);
`endif
    match_d = $signed(diff_d) >= $signed(Bus.Threshold);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      col_q       <= '0;
      row_q       <= '0;
      frameDone_q <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      cornA_q     <= '0;
      cornB_q     <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      sumA_q      <= '0;
      sumB_q      <= '0;
      outValid_q  <= 1'b0;
      outDiff_q   <= '0;
      outMatch_q  <= 1'b0;
      outX_q      <= '0;
      outY_q      <= '0;
    end else begin
      frameDone_q <= 1'b0;
      if (Bus.InValid) begin
        if (col_q == XW'(ImageWidth-1)) begin
          col_q <= '0;
          if (row_q == YW'(ImageHeight-1)) begin
            row_q       <= '0;
            frameDone_q <= 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      v1_q    <= qual;
      cornA_q <= cornA_d;
      cornB_q <= cornB_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      v2_q    <= v1_q;
      sumA_q  <= sumA_d;
      sumB_q  <= sumB_d;
      x2_q    <= x1_q;
      y2_q    <= y1_q;
      outValid_q <= v2_q;
      // Result fields hold their last value between valid outputs.
      if (v2_q) begin
        outDiff_q  <= diff_d;
        outMatch_q <= match_d;
        outX_q     <= x2_q;
        outY_q     <= y2_q;
      end
    end
  end

  assign Bus.OutValid  = outValid_q;
  assign Bus.OutDiff   = outDiff_q;
  assign Bus.OutMatch  = outMatch_q;
  assign Bus.OutX      = outX_q;
  assign Bus.OutY      = outY_q;
  assign Bus.FrameDone = frameDone_q;
endmodule

// File: tb/tb_haar_window_feature.sv
// Scoreboard bench for haar_window_feature on an 8x4 image with a 3x3 window.
// Expectations follow HAAR_FEATURE_ABS_EN when it is defined for the build.
module tb_haar_window_feature;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = 3;
`ifdef HAAR_FEATURE_ABS_EN
  localparam bit AbsMode = 1'b1;
`else
  localparam bit AbsMode = 1'b0;
`endif

  typedef struct {
    logic [4:0] diff;
    logic       match;
    logic [2:0] x;
    logic [1:0] y;
  } expT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   totalCount = 0;
  int   badCount = 0;
  int   validCount = 0;
  int   frameDoneCount = 0;
  expT  expQ[$];
  logic [35:0] onesWin, dotWin;

  haar_window_feature_if #(.ImageWidth(W), .ImageHeight(H), .WindowSize(N)) bus ();

  haar_window_feature #(.ImageWidth(W), .ImageHeight(H), .WindowSize(N)) dut (
    .Clock(clock),
    .Reset(reset),
    .Bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Window with every pixel set (I = (x+1)(y+1)) or a single set pixel at (1,1).
  function automatic logic [35:0] makeWindow(input bit singleOne);
    logic [35:0] w;
    w = '0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        if (singleOne) w[4*(N*y+x) +: 4] = (x >= 1 && y >= 1) ? 4'd1 : 4'd0;
        else           w[4*(N*y+x) +: 4] = 4'((x+1)*(y+1));
    return w;
  endfunction

  task automatic setConfig(input logic [1:0] ax0, ay0, ax1, ay1, bx0, by0, bx1, by1,
                           input logic [4:0] thr);
    bus.RectAX0 = ax0; bus.RectAY0 = ay0; bus.RectAX1 = ax1; bus.RectAY1 = ay1;
    bus.RectBX0 = bx0; bus.RectBY0 = by0; bus.RectBX1 = bx1; bus.RectBY1 = by1;
    bus.Threshold = thr;
  endtask

  task automatic applyStimulus(input logic ready, input logic [35:0] win, input bit expectOut,
                               input logic [4:0] eDiff, input logic eMatch,
                               input logic [2:0] ex, input logic [1:0] ey);
    expT e;
    @(negedge clock);
    bus.InValid = 1'b1;
    bus.BufferReady = ready;
    bus.IntegralPacked = win;
    if (expectOut) begin
      e.diff = eDiff; e.match = eMatch; e.x = ex; e.y = ey;
      expQ.push_back(e);
    end
  endtask

  task automatic skipPixels(input int count, input logic ready);
    for (int i = 0; i < count; i++) applyStimulus(ready, onesWin, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0);
  endtask

  task automatic idleCycles(input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clock);
      bus.InValid = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clock) begin
    expT e;
    if (bus.FrameDone) frameDoneCount++;
    if (bus.OutValid) begin
      validCount++;
      if (expQ.size() == 0) begin
        totalCount++;
        badCount++;
        $display("[TB] FAIL unexpectedOutValid: got OutValid=1 with OutX=%0d OutY=%0d, required none",
                 bus.OutX, bus.OutY);
      end else begin
        e = expQ.pop_front();
        checkOutput("OutDiff",  32'(bus.OutDiff),  32'(e.diff));
        checkOutput("OutMatch", 32'(bus.OutMatch), 32'(e.match));
        checkOutput("OutX",     32'(bus.OutX),     32'(e.x));
        checkOutput("OutY",     32'(bus.OutY),     32'(e.y));
      end
    end
  end

  initial begin
    onesWin = makeWindow(1'b0);
    dotWin  = makeWindow(1'b1);
    bus.InValid = 1'b0;
    bus.BufferReady = 1'b0;
    bus.IntegralPacked = '0;
    setConfig(0, 0, 2, 2, 1, 1, 1, 1, 5'd8);

    repeat (3) begin
      @(negedge clock);
      checkOutput("OutValid during reset", 32'(bus.OutValid), 0);
    end
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset OutValid",  32'(bus.OutValid),  0);
    checkOutput("reset OutDiff",   32'(bus.OutDiff),   0);
    checkOutput("reset OutMatch",  32'(bus.OutMatch),  0);
    checkOutput("reset OutX",      32'(bus.OutX),      0);
    checkOutput("reset OutY",      32'(bus.OutY),      0);
    checkOutput("reset FrameDone", 32'(bus.FrameDone), 0);

    // Rows 0 and 1 never qualify, whatever BufferReady says.
    skipPixels(W, 1'b1);
    skipPixels(W, 1'b0);

    // Row 2: cols 0-1 straddle the line start, col 2 is the first window.
    skipPixels(2, 1'b1);
    applyStimulus(1'b1, onesWin, 1'b1, 5'd8, 1'b1, 3'd0, 2'd0);
    @(negedge clock);
    bus.InValid = 1'b0;
    checkOutput("latency cycle1 OutValid", 32'(bus.OutValid), 0);
    @(negedge clock);
    checkOutput("latency cycle2 OutValid", 32'(bus.OutValid), 0);
    @(negedge clock);
    checkOutput("latency cycle3 OutValid", 32'(bus.OutValid), 1);
    for (int c = 3; c < W; c++) applyStimulus(1'b1, onesWin, 1'b1, 5'd8, 1'b1, 3'(c-2), 2'd0);
    idleCycles(5);
    checkOutput("row2 pulse count", 32'(validCount), 6);
    checkOutput("hold OutValid", 32'(bus.OutValid), 0);
    checkOutput("hold OutDiff",  32'(bus.OutDiff),  8);
    checkOutput("hold OutX",     32'(bus.OutX),     5);

    // Row 3: one configuration per pixel, pipeline drained between changes.
    skipPixels(2, 1'b0);
    setConfig(0, 0, 2, 2, 1, 1, 1, 1, 5'd9);
    applyStimulus(1'b1, onesWin, 1'b1, 5'd8, 1'b0, 3'd0, 2'd1);
    idleCycles(4);
    setConfig(1, 1, 1, 1, 0, 0, 2, 2, 5'd8);
    applyStimulus(1'b1, onesWin, 1'b1, AbsMode ? 5'd8 : 5'd24, AbsMode, 3'd1, 2'd1);
    idleCycles(4);
    setConfig(2, 0, 1, 2, 1, 1, 1, 1, 5'd30);
    applyStimulus(1'b1, onesWin, 1'b1, AbsMode ? 5'd1 : 5'd31, 1'b1, 3'd2, 2'd1);
    idleCycles(4);
    setConfig(0, 2, 2, 1, 2, 2, 2, 2, 5'd30);
    applyStimulus(1'b1, onesWin, 1'b1, AbsMode ? 5'd1 : 5'd31, 1'b1, 3'd3, 2'd1);
    idleCycles(4);
    setConfig(0, 0, 2, 2, 1, 0, 2, 1, 5'd1);
    applyStimulus(1'b1, dotWin, 1'b1, 5'd0, 1'b0, 3'd4, 2'd1);
    idleCycles(4);
    checkOutput("FrameDone before last pixel", 32'(frameDoneCount), 0);
    setConfig(1, 0, 2, 2, 0, 1, 2, 1, 5'd3);
    applyStimulus(1'b1, onesWin, 1'b1, 5'd3, 1'b1, 3'd5, 2'd1);
    @(negedge clock);
    bus.InValid = 1'b0;
    checkOutput("FrameDone pulse", 32'(bus.FrameDone), 1);
    @(negedge clock);
    checkOutput("FrameDone drop", 32'(bus.FrameDone), 0);
    idleCycles(4);

    // Second frame restarts positions at (0,0).
    setConfig(0, 0, 2, 2, 1, 1, 1, 1, 5'd8);
    skipPixels(2*W + 2, 1'b1);
    applyStimulus(1'b1, onesWin, 1'b1, 5'd8, 1'b1, 3'd0, 2'd0);
    idleCycles(4);

    // Reset one cycle after a qualified pixel discards it and rewinds the counters.
    applyStimulus(1'b1, onesWin, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0);
    @(negedge clock);
    bus.InValid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idleCycles(5);
    checkOutput("pulses after mid-flight reset", 32'(validCount), 13);
    skipPixels(2*W + 2, 1'b0);
    applyStimulus(1'b1, onesWin, 1'b1, 5'd8, 1'b1, 3'd0, 2'd0);
    idleCycles(5);

    checkOutput("total OutValid pulses", 32'(validCount), 14);
    checkOutput("scoreboard empty", 32'(expQ.size()), 0);
    checkOutput("FrameDone pulses", 32'(frameDoneCount), 1);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end
endmodule

// File: doc/haar_window_feature.md
Name: haar_window_feature

Overview:
- Downstream consumer of the integral-window buffer stage.
- Takes the packed n×n integral window once per accepted pixel and computes two rectangle sums, A and B, using the 4-corner formula.
- Outputs the signed difference A−B, a threshold match flag, and the window's image coordinates.
- Feeds the detection/NMS stage; 3-stage pipeline, one result per input strobe.

Parameters:
- ImageWidth, 640, pixels per line; column counter wrap point.
- ImageHeight, 480, lines per frame; row counter wrap point.
- WindowSize, 21, n; window side; must match the upstream buffer.
- Derived, not overridable: IW = clog2(n*n+1) integral bits; CW = clog2(n) corner index bits; XW = clog2(ImageWidth); YW = clog2(ImageHeight); DW = IW+1 signed difference bits.

Ports:
- Clock  in  1  clock; Reset is synchronous, active-high.
- Reset  in  1  synchronous active-high reset.
- InValid  in  1  one pulse per pixel; IntegralPacked is valid in the same cycle.
- BufferReady  in  1  upstream window fully populated.
- IntegralPacked  in  IW*n*n  entry k=n*y+x at bits [IW*k+IW-1 : IW*k]. Entry value = count of ones in window rows 0..y, cols 0..x inclusive.
- RectAX0, RectAY0, RectAX1, RectAY1  in  CW each  rect A inclusive corners; static config.
- RectBX0, RectBY0, RectBX1, RectBY1  in  CW each  rect B inclusive corners; static config.
- Threshold  in  DW  signed compare threshold; static config.
- OutValid  out  1  result valid.
- OutDiff  out  DW  signed A−B.
- OutMatch  out  1  OutDiff >= Threshold (signed compare).
- OutX  out  XW  window top-left column in image.
- OutY  out  YW  window top-left row in image.
- FrameDone  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset: all outputs 0; col/row counters 0; all pipeline valid bits 0. Reset mid-frame discards in-flight results; no OutValid in the cycle after Reset.

Position counters (update on InValid only):
- col increments; at ImageWidth−1 it wraps to 0 and row increments.
- At col=ImageWidth−1 and row=ImageHeight−1: row wraps to 0, FrameDone=1 for exactly that cycle + 1, aligned with the registered counter update.
- Counters are independent of BufferReady.

Window qualification (S0, combinational on input):
- qual = InValid & BufferReady & (col >= n−1) & (row >= n−1).
- Rejects windows straddling a line wrap.

S1, registered:
- For each rect, latch four corners: D=I(x1,y1), B=I(x0−1,y1), C=I(x1,y0−1), A=I(x0−1,y0−1).
- Any corner with index −1 (x0=0 or y0=0) reads 0.
- Latch X=col−(n−1), Y=row−(n−1).
- Valid pipeline bit v1 <= qual.

S2, registered:
- SumA = D−B−C+A and SumB likewise, computed at IW+2 bits, then truncated to IW (result is always 0..n*n).
- Malformed rect (x0>x1 or y0>y1): sum forced 0.
- v2 <= v1.

S3, registered:
- OutDiff = SumA − SumB, sign-extended to DW.
- OutMatch per compare rule; OutValid <= v2.
- When v2=0: OutValid=0; OutDiff/OutMatch/OutX/OutY hold their last values.

Timing and flow:
- Latency: InValid at cycle t → OutValid at t+3.
- Throughput 1/cycle; back-to-back InValid supported.
- No stall or ready input; downstream must accept every OutValid.
- Config ports are sampled every cycle; changing them mid-frame affects results in flight. Change only between frames.

Optional Feature:
- Macro HAAR_FEATURE_ABS_EN.
- Defined: OutDiff = |SumA − SumB| (non-negative, DW bits); OutMatch = |A−B| >= Threshold.
- Not defined: signed difference and signed compare as above.

Test Plan:
- Reset, then 1 InValid with BufferReady=1 at col=row=n−1 → OutValid=0 for cycles 1–2, OutValid=1 at cycle 3; no output during reset.
- n=3, ImageWidth=8, all-ones window (I(x,y)=(x+1)(y+1)), A=(0,0)-(2,2), B=(1,1)-(1,1), Threshold=8 → OutDiff=8, OutMatch=1.
- Same window, Threshold=9 → OutMatch=0. Swap A/B → OutDiff=−8. With HAAR_FEATURE_ABS_EN → OutDiff=8.
- Stream 8 pixels on row 2 with BufferReady=1 → exactly 6 OutValid pulses, OutX=0..5, OutY=0. Col 0–1 produce none.
- Full 8×4 frame at n=3 → FrameDone single pulse after the 32nd InValid; counters return to (0,0); next frame restarts OutX/OutY at 0.
- Malformed rect A x0=2, x1=1 → SumA=0. Reset asserted 1 cycle after InValid → no OutValid emitted.
